// File: rtl/wb_mcu_master.sv
// wb_mcu_master: bridges the MCU 8-bit asynchronous SRAM bus (ncs/nwe/nrd)
// onto a 16-bit Wishbone fabric. Each MCU byte access becomes one Wishbone
// single cycle. Reads land in a word latch so a following high-byte read of
// the same word is answered without a bus cycle. Stuck slaves are aborted
// by an ack timeout.
module wb_mcu_master #(
    parameter int ADDR_WIDTH     = 15,
    parameter int DATA_WIDTH     = 16,
    parameter int MCU_ADDR_WIDTH = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT        = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      mcu_ncs,
    input  logic                      mcu_nwe,
    input  logic                      mcu_nrd,
    input  logic [MCU_ADDR_WIDTH-1:0] mcu_addr,
    input  logic [7:0]                mcu_data_i,
    output logic [7:0]                mcu_data_o,
    output logic                      mcu_data_oe,
    output logic                      wb_cyc_o,
    output logic                      wb_stb_o,
    output logic                      wb_we_o,
    output logic [ADDR_WIDTH-1:0]     wb_adr_o,
    output logic [DATA_WIDTH-1:0]     wb_dat_o,
    output logic [1:0]                wb_sel_o,
    input  logic [DATA_WIDTH-1:0]     wb_dat_i,
    input  logic                      wb_ack_i,
    output logic                      timeout_o,
    output logic                      overrun_o,
    input  logic                      clr_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_WR, ST_RD} state_t;

    // Last count value before the abort fires: stb stays high TIMEOUT cycles.
    localparam logic [9:0] TO_LAST = 10'(TIMEOUT - 1);

    logic [SYNC_STAGES-1:0]    ncs_sync_reg, nwe_sync_reg, nrd_sync_reg;
    logic                      s_ncs, s_nwe, s_nrd;
    logic                      s_ncs_d_reg, s_nwe_d_reg, s_nrd_d_reg;
    logic [MCU_ADDR_WIDTH-1:0] cap_adr_reg, wr_adr_reg;
    logic [7:0]                cap_dat_reg, wr_dat_reg;
    logic [ADDR_WIDTH-1:0]     cap_wadr, wr_wadr, lat_adr_reg;
    logic [DATA_WIDTH-1:0]     lat_dat_reg;
    logic                      lat_vld_reg, wr_pend_reg, rd_pend_reg;
    logic                      wr_evt, rd_evt, wr_take, rd_take, rd_hit;
    logic [9:0]                to_cnt_reg;
    state_t                    state_reg;

    assign s_ncs = ncs_sync_reg[SYNC_STAGES-1];
    assign s_nwe = nwe_sync_reg[SYNC_STAGES-1];
    assign s_nrd = nrd_sync_reg[SYNC_STAGES-1];

    // Byte address -> word address, zero-extended or truncated bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < ADDR_WIDTH; gi++) begin : g_wadr
            if (gi + 1 < MCU_ADDR_WIDTH) begin : g_bit
                assign cap_wadr[gi] = cap_adr_reg[gi+1];
                assign wr_wadr[gi]  = wr_adr_reg[gi+1];
            end else begin : g_zero
                assign cap_wadr[gi] = 1'b0;
                assign wr_wadr[gi]  = 1'b0;
            end
        end
    endgenerate

    // Write fires after the strobe ends; previous ncs lets ncs rise with nwe.
    assign wr_evt  = s_nwe & ~s_nwe_d_reg & ~s_ncs_d_reg;
    assign rd_evt  = ~s_nrd & s_nrd_d_reg & ~s_ncs;
    assign wr_take = (state_reg == ST_IDLE) & wr_pend_reg;
    assign rd_take = (state_reg == ST_IDLE) & ~wr_pend_reg & rd_pend_reg;
    assign rd_hit  = cap_adr_reg[0] & lat_vld_reg & (cap_wadr == lat_adr_reg);

    assign mcu_data_o  = cap_adr_reg[0] ? lat_dat_reg[15:8] : lat_dat_reg[7:0];
    assign mcu_data_oe = ~mcu_nrd & ~mcu_ncs;

    // Strobe synchronizers plus one delayed copy for edge detection.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ncs_sync_reg <= '1;
            nwe_sync_reg <= '1;
            nrd_sync_reg <= '1;
            s_ncs_d_reg  <= 1'b1;
            s_nwe_d_reg  <= 1'b1;
            s_nrd_d_reg  <= 1'b1;
        end else begin
            ncs_sync_reg <= {ncs_sync_reg[SYNC_STAGES-2:0], mcu_ncs};
            nwe_sync_reg <= {nwe_sync_reg[SYNC_STAGES-2:0], mcu_nwe};
            nrd_sync_reg <= {nrd_sync_reg[SYNC_STAGES-2:0], mcu_nrd};
            s_ncs_d_reg  <= s_ncs;
            s_nwe_d_reg  <= s_nwe;
            s_nrd_d_reg  <= s_nrd;
        end
    end

    // Track address/data while a strobe is active; pins are stable by then.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cap_adr_reg <= '0;
            cap_dat_reg <= '0;
        end else if (~s_ncs & (~s_nwe | ~s_nrd)) begin
            cap_adr_reg <= mcu_addr;
            cap_dat_reg <= mcu_data_i;
        end
    end

    // Pending flags; an accepted write snapshots its address/data so a later
    // MCU access cannot corrupt it while an earlier cycle is still on the bus.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_pend_reg <= 1'b0;
            rd_pend_reg <= 1'b0;
            overrun_o   <= 1'b0;
            wr_adr_reg  <= '0;
            wr_dat_reg  <= '0;
        end else begin
            if (clr_i) overrun_o <= 1'b0;
            if (wr_take) wr_pend_reg <= 1'b0;
            if (rd_take) rd_pend_reg <= 1'b0;
            if (wr_evt) begin
                if (wr_pend_reg && !wr_take) begin
                    overrun_o <= 1'b1;
                end else begin
                    wr_pend_reg <= 1'b1;
                    wr_adr_reg  <= cap_adr_reg;
                    wr_dat_reg  <= cap_dat_reg;
                end
            end
            if (rd_evt) begin
                if (rd_pend_reg && !rd_take) overrun_o <= 1'b1;
                else                         rd_pend_reg <= 1'b1;
            end
        end
    end

    // Bus FSM: launches cycles, handles ack/timeout, maintains the read latch.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_IDLE;
            wb_cyc_o    <= 1'b0;
            wb_stb_o    <= 1'b0;
            wb_we_o     <= 1'b0;
            wb_adr_o    <= '0;
            wb_dat_o    <= '0;
            wb_sel_o    <= '0;
            to_cnt_reg  <= '0;
            lat_dat_reg <= '0;
            lat_adr_reg <= '0;
            lat_vld_reg <= 1'b0;
            timeout_o   <= 1'b0;
        end else begin
            if (clr_i) timeout_o <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (wr_take) begin
                        wb_cyc_o    <= 1'b1;
                        wb_stb_o    <= 1'b1;
                        wb_we_o     <= 1'b1;
                        wb_adr_o    <= wr_wadr;
                        wb_sel_o    <= wr_adr_reg[0] ? 2'b10 : 2'b01;
                        wb_dat_o    <= {wr_dat_reg, wr_dat_reg};
                        to_cnt_reg  <= '0;
                        lat_vld_reg <= 1'b0;
                        state_reg   <= ST_WR;
                    end else if (rd_take && !rd_hit) begin
                        wb_cyc_o   <= 1'b1;
                        wb_stb_o   <= 1'b1;
                        wb_we_o    <= 1'b0;
                        wb_adr_o   <= cap_wadr;
                        wb_sel_o   <= cap_adr_reg[0] ? 2'b10 : 2'b01;
                        wb_dat_o   <= {cap_dat_reg, cap_dat_reg};
                        to_cnt_reg <= '0;
                        state_reg  <= ST_RD;
                    end
                end
                default: begin
                    if (wb_ack_i) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        state_reg <= ST_IDLE;
                        if (state_reg == ST_RD) begin
                            lat_dat_reg <= wb_dat_i;
                            lat_adr_reg <= wb_adr_o;
                            lat_vld_reg <= 1'b1;
                        end
                    end else if (to_cnt_reg == TO_LAST) begin
                        wb_cyc_o  <= 1'b0;
                        wb_stb_o  <= 1'b0;
                        wb_we_o   <= 1'b0;
                        timeout_o <= 1'b1;
                        state_reg <= ST_IDLE;
                        if (state_reg == ST_RD) begin
                            lat_dat_reg <= '1;
                            lat_vld_reg <= 1'b0;
                        end
                    end else begin
                        to_cnt_reg <= to_cnt_reg + 10'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_mcu_master.sv
// Testbench for wb_mcu_master: MCU-side driver tasks, a Wishbone slave with
// programmable ack latency, and a word-level reference model of the MCU's
// view (memory image plus the read-word latch).
module tb_wb_mcu_master;

    localparam int S   = 2;
    localparam int TMO = 60;

    logic        clk = 1'b0;
    logic        rst_i, mcu_ncs, mcu_nwe, mcu_nrd, clr_i, wb_ack_i;
    logic [15:0] mcu_addr, wb_dat_i, wb_dat_o;
    logic [7:0]  mcu_data_i, mcu_data_o;
    logic        mcu_data_oe, wb_cyc_o, wb_stb_o, wb_we_o, timeout_o, overrun_o;
    logic [14:0] wb_adr_o;
    logic [1:0]  wb_sel_o;

    always #5 clk = ~clk;

    wb_mcu_master #(
        .ADDR_WIDTH(15), .DATA_WIDTH(16), .MCU_ADDR_WIDTH(16),
        .SYNC_STAGES(S), .TIMEOUT(TMO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .mcu_ncs(mcu_ncs), .mcu_nwe(mcu_nwe), .mcu_nrd(mcu_nrd),
        .mcu_addr(mcu_addr), .mcu_data_i(mcu_data_i),
        .mcu_data_o(mcu_data_o), .mcu_data_oe(mcu_data_oe),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .timeout_o(timeout_o), .overrun_o(overrun_o), .clr_i(clr_i)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [14:0] adr;
        logic [1:0]  sel;
        logic        we;
        logic [15:0] dat;
        int          len;   // expected stb-high cycles, -1 when aborted by reset
    } bus_t;

    bus_t        expq[$];
    logic [15:0] ref_mem [0:255];
    logic [15:0] slv_mem [0:255];
    bit          m_vld;
    logic [14:0] m_word;
    logic [15:0] m_dat;
    int          ack_lat;     // 0 = slave never acks
    int          cyc_cnt = 0;
    int          launch_cyc = 0;
    int          raise_cyc = 0;

    always @(posedge clk) cyc_cnt++;

    // Wishbone slave: ack after ack_lat stb-high cycles.
    int scnt = 0;
    always @(negedge clk) begin
        if (rst_i || !(wb_cyc_o && wb_stb_o) || wb_ack_i) begin
            wb_ack_i = 1'b0;
            scnt = 0;
        end else begin
            scnt++;
            if (ack_lat != 0 && scnt == ack_lat) begin
                wb_ack_i = 1'b1;
                if (wb_we_o) begin
                    if (wb_sel_o[0]) slv_mem[wb_adr_o[7:0]][7:0]  = wb_dat_o[7:0];
                    if (wb_sel_o[1]) slv_mem[wb_adr_o[7:0]][15:8] = wb_dat_o[15:8];
                end else begin
                    wb_dat_i = slv_mem[wb_adr_o[7:0]];
                end
            end
        end
    end

    // Bus monitor: each launched cycle must match the next expected one.
    bit   stb_prev = 1'b0;
    bit   active = 1'b0;
    int   cur_len = 0;
    bus_t cur_e;
    always @(negedge clk) begin
        if (wb_stb_o && !stb_prev) begin
            launch_cyc = cyc_cnt;
            cur_len = 0;
            if (expq.size() == 0) begin
                check_eq("unexpected_cycle", 32'(expq.size()), 32'd1);
                active = 1'b0;
            end else begin
                cur_e = expq.pop_front();
                active = 1'b1;
                check_eq("bus_adr", 32'(wb_adr_o), 32'(cur_e.adr));
                check_eq("bus_sel", 32'(wb_sel_o), 32'(cur_e.sel));
                check_eq("bus_we", 32'(wb_we_o), 32'(cur_e.we));
                check_eq("bus_cyc", 32'(wb_cyc_o), 32'd1);
                if (cur_e.we) check_eq("bus_dat", 32'(wb_dat_o), 32'(cur_e.dat));
            end
        end
        if (wb_stb_o) cur_len++;
        if (!wb_stb_o && stb_prev && active) begin
            active = 1'b0;
            if (cur_e.len >= 0) check_eq("stb_len", 32'(cur_len), 32'(cur_e.len));
            check_eq("cyc_drop", 32'(wb_cyc_o), 32'd0);
        end
        stb_prev = wb_stb_o;
    end

    task automatic mcu_write(input logic [15:0] a, input logic [7:0] d,
                             input bit accepted, input bit wait_done);
        bus_t e;
        int   len;
        len = (ack_lat == 0) ? TMO : ack_lat;
        if (accepted) begin
            e.adr = a[15:1];
            e.sel = a[0] ? 2'b10 : 2'b01;
            e.we  = 1'b1;
            e.dat = {d, d};
            e.len = len;
            expq.push_back(e);
            if (ack_lat != 0) begin
                if (a[0]) ref_mem[a[8:1]][15:8] = d;
                else      ref_mem[a[8:1]][7:0]  = d;
            end
            m_vld = 1'b0;
        end
        $display("mcu wr addr=%04h data=%02h", a, d);
        @(posedge clk); #2;
        mcu_addr = a; mcu_data_i = d; mcu_ncs = 1'b0; mcu_nwe = 1'b0;
        repeat (S + 2) @(posedge clk);
        #2;
        mcu_nwe = 1'b1; mcu_ncs = 1'b1;
        raise_cyc = cyc_cnt;
        repeat (S + 1) @(posedge clk);
        if (wait_done) repeat (len + 4) @(posedge clk);
    endtask

    task automatic mcu_read(input logic [15:0] a);
        bus_t       e;
        bit         hit;
        logic [7:0] exp_b;
        int         len;
        hit = a[0] && m_vld && (a[15:1] == m_word);
        len = 0;
        if (!hit) begin
            len   = (ack_lat == 0) ? TMO : ack_lat;
            e.adr = a[15:1];
            e.sel = a[0] ? 2'b10 : 2'b01;
            e.we  = 1'b0;
            e.dat = 16'h0;
            e.len = len;
            expq.push_back(e);
            if (ack_lat == 0) begin
                m_dat = 16'hFFFF;
                m_vld = 1'b0;
            end else begin
                m_dat  = ref_mem[a[8:1]];
                m_vld  = 1'b1;
                m_word = a[15:1];
            end
        end
        exp_b = a[0] ? m_dat[15:8] : m_dat[7:0];
        @(posedge clk); #2;
        mcu_addr = a; mcu_ncs = 1'b0; mcu_nrd = 1'b0;
        repeat (S + 4 + len + 2) @(posedge clk);
        @(negedge clk);
        check_eq("rd_oe", 32'(mcu_data_oe), 32'd1);
        check_eq("rd_data", 32'(mcu_data_o), 32'(exp_b));
        $display("mcu rd addr=%04h data=%02h expect=%02h %s", a, mcu_data_o, exp_b,
                 hit ? "latched" : "bus");
        @(posedge clk); #2;
        mcu_nrd = 1'b1; mcu_ncs = 1'b1;
        #1 check_eq("rd_oe_off", 32'(mcu_data_oe), 32'd0);
        repeat (S + 2) @(posedge clk);
    endtask

    task automatic pulse_clr();
        @(posedge clk); #2 clr_i = 1'b1;
        @(posedge clk); #2 clr_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got hang, expected $finish");
        $fatal(1);
    end

    initial begin
        bus_t e;
        int   w;
        rst_i = 1'b1; mcu_ncs = 1'b1; mcu_nwe = 1'b1; mcu_nrd = 1'b1;
        mcu_addr = '0; mcu_data_i = '0; clr_i = 1'b0;
        wb_ack_i = 1'b0; wb_dat_i = '0;
        ack_lat = 1; m_vld = 1'b0; m_dat = '0; m_word = '0;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 16'($urandom);
            slv_mem[i] = ref_mem[i];
        end
        ref_mem[8] = 16'h1234;
        slv_mem[8] = 16'h1234;

        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        @(negedge clk);
        check_eq("rst_cyc", 32'(wb_cyc_o), 0);
        check_eq("rst_stb", 32'(wb_stb_o), 0);
        check_eq("rst_we", 32'(wb_we_o), 0);
        check_eq("rst_adr", 32'(wb_adr_o), 0);
        check_eq("rst_sel", 32'(wb_sel_o), 0);
        check_eq("rst_dat", 32'(wb_dat_o), 0);
        check_eq("rst_mcu_data", 32'(mcu_data_o), 0);
        check_eq("rst_timeout", 32'(timeout_o), 0);
        check_eq("rst_overrun", 32'(overrun_o), 0);
        check_eq("rst_oe", 32'(mcu_data_oe), 0);

        // Word pair: low byte from the bus, high byte from the latch.
        ack_lat = 2;
        mcu_read(16'h0010);
        mcu_read(16'h0011);
        check_eq("pair_one_read", 32'(expq.size()), 0);

        // Low-byte write with a 3-cycle ack; check event-to-launch latency.
        ack_lat = 3;
        mcu_write(16'h0010, 8'hA5, 1'b1, 1'b1);
        check_eq("wr_latency", 32'(launch_cyc - raise_cyc), 32'(S + 2));

        // A write invalidates the latch, forcing a fresh bus read.
        mcu_read(16'h0010);
        mcu_write(16'h0011, 8'h5A, 1'b1, 1'b1);
        mcu_read(16'h0011);
        check_eq("inval_reread", 32'(expq.size()), 0);

        // Timeout: slave silent, stb high TMO cycles, MCU reads 0xFF.
        check_eq("to_before", 32'(timeout_o), 0);
        ack_lat = 0;
        mcu_read(16'h0020);
        check_eq("to_flag", 32'(timeout_o), 1);
        pulse_clr();
        check_eq("to_cleared", 32'(timeout_o), 0);

        // Overrun: slow slave, three back-to-back writes, third dropped.
        ack_lat = 50;
        check_eq("ovr_before", 32'(overrun_o), 0);
        mcu_write(16'h0030, 8'h11, 1'b1, 1'b0);
        mcu_write(16'h0032, 8'h22, 1'b1, 1'b0);
        mcu_write(16'h0034, 8'h33, 1'b0, 1'b0);
        repeat (2 * 50 + 20) @(posedge clk);
        @(negedge clk);
        check_eq("ovr_flag", 32'(overrun_o), 1);
        check_eq("ovr_two_done", 32'(expq.size()), 0);
        ack_lat = 2;
        mcu_read(16'h0030);
        mcu_read(16'h0032);
        mcu_read(16'h0034);
        pulse_clr();
        check_eq("ovr_cleared", 32'(overrun_o), 0);

        // Reset mid-read: prime the latch on word 0x11, then abort a read.
        mcu_read(16'h0022);
        ack_lat = 0;
        e.adr = 15'h0011; e.sel = 2'b01; e.we = 1'b0; e.dat = 16'h0; e.len = -1;
        expq.push_back(e);
        @(posedge clk); #2;
        mcu_addr = 16'h0022; mcu_ncs = 1'b0; mcu_nrd = 1'b0;
        w = 0;
        while (!wb_stb_o && w < 20) begin
            @(negedge clk);
            w++;
        end
        check_eq("rstrd_stb_seen", 32'(wb_stb_o), 1);
        @(posedge clk); #2 rst_i = 1'b1;
        @(negedge clk);
        check_eq("rstrd_oe_pins", 32'(mcu_data_oe), 1);
        @(negedge clk);
        check_eq("rstrd_cyc", 32'(wb_cyc_o), 0);
        check_eq("rstrd_stb", 32'(wb_stb_o), 0);
        check_eq("rstrd_we", 32'(wb_we_o), 0);
        check_eq("rstrd_adr", 32'(wb_adr_o), 0);
        check_eq("rstrd_sel", 32'(wb_sel_o), 0);
        check_eq("rstrd_mcu_data", 32'(mcu_data_o), 0);
        @(posedge clk); #2;
        mcu_ncs = 1'b1; mcu_nrd = 1'b1;
        repeat (S + 2) @(posedge clk);
        #2 rst_i = 1'b0;
        m_vld = 1'b0; m_dat = 16'h0;
        ack_lat = 2;
        mcu_read(16'h0023);
        check_eq("rstrd_reread", 32'(expq.size()), 0);

        // Randomized mix over a small window so latch hits happen.
        for (int k = 0; k < 40; k++) begin
            logic [15:0] a;
            a = 16'($urandom_range(0, 31));
            ack_lat = $urandom_range(1, 5);
            if ($urandom_range(0, 99) < 40) mcu_write(a, 8'($urandom), 1'b1, 1'b1);
            else                            mcu_read(a);
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_eq("final_queue_empty", 32'(expq.size()), 0);
        check_eq("final_timeout", 32'(timeout_o), 0);
        check_eq("final_overrun", 32'(overrun_o), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
